// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart tx arbiter: FSM state encoding, byte width,
// and the rotating first-one search used by the round-robin selector.
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // First set bit of req at or after ptr, wrapping modulo n; -1 when none is set.
    function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int idx;
        int res;
        res = -1;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + int'(k);
            if (idx >= n) idx = idx - n;
            if (int'(k) < n && res < 0 && req[idx[2:0]]) res = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner and index of the first
// asserted request at or after rr_ptr.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_req
);

    logic [MAX_REQ-1:0] req_ext;
    int                 pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_first(req_ext, int'(rr_ptr), NUM_REQ);
        any_req              = (pick >= 0);
        winner_idx           = any_req ? PTR_W'(pick) : '0;
        winner               = '0;
        if (any_req) winner[winner_idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buart transmitter among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to release a grant left idle for TIMEOUT_CYCLES in ISSUE.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      uart_wr,
    output logic [BYTE_W-1:0]         uart_tx_data,
    input  logic                      uart_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic               is_last;
    logic               xfer;
    logic [SET_W-1:0]   settle_cnt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .rr_ptr     (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    assign xfer      = (state == ISSUE) && req_valid[g_idx] && !uart_busy;
    assign req_ready = (xfer && !reset) ? grant : '0;
    assign next_ptr  = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W     = (TO_W_RAW < 20) ? 20 : TO_W_RAW;

    logic [TO_W-1:0] idle_cnt;
    logic            timed_out;

    assign timed_out = (state == ISSUE) && !req_valid[g_idx] &&
                       (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            g_idx        <= '0;
            rr_ptr       <= '0;
            uart_wr      <= 1'b0;
            uart_tx_data <= '0;
            is_last      <= 1'b0;
            settle_cnt   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            uart_wr <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            if (state != ISSUE || xfer) idle_cnt <= '0;
            else if (!req_valid[g_idx]) idle_cnt <= idle_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_onehot;
                        g_idx <= pick_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        uart_wr      <= 1'b1;
                        uart_tx_data <= req_data[int'(g_idx)*BYTE_W +: BYTE_W];
                        is_last      <= req_last[g_idx];
                        settle_cnt   <= '0;
                        state        <= SETTLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (timed_out) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
`endif
                end
                SETTLE: begin
                    // settle_cnt counts cycles since the strobe, so the exit test looks one ahead
                    if (settle_cnt != SET_W'(SETTLE_CYCLES)) settle_cnt <= settle_cnt + 1'b1;
                    if (uart_busy || settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (!uart_busy) begin
                        if (is_last) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
